// File: rtl/image_writer_if.sv
// image_writer_if: command, pixel-stream and RAM-write signals of the
// palette-indexed framebuffer writer.
//   cmd_*   rectangle command handshake (x0, y0, w, h)
//   pix_*   palette-index stream handshake
//   wEn/addr/dataIn  image-data RAM write port
//   busy/done        status
// Optional macro IMAGE_WRITER_FILL_EN adds cmd_fill and cmd_index.
// Modports: master drives commands and pixels; slave is the writer.
interface image_writer_if #(
  parameter int WIDTH                 = 640,
  parameter int HEIGHT                = 480,
  parameter int PIXEL_ADDRESS_WIDTH   = $clog2(WIDTH*HEIGHT)+1,
  parameter int PALETTE_ADDRESS_WIDTH = $clog2(256)+1,
  parameter int X_WIDTH               = $clog2(WIDTH)+1,
  parameter int Y_WIDTH               = $clog2(HEIGHT)+1
);
  logic                             cmd_valid;
  logic                             cmd_ready;
  logic [X_WIDTH-1:0]               cmd_x0;
  logic [Y_WIDTH-1:0]               cmd_y0;
  logic [X_WIDTH-1:0]               cmd_w;
  logic [Y_WIDTH-1:0]               cmd_h;
`ifdef IMAGE_WRITER_FILL_EN
  logic                             cmd_fill;
  logic [PALETTE_ADDRESS_WIDTH-1:0] cmd_index;
`endif
  logic                             pix_valid;
  logic                             pix_ready;
  logic [PALETTE_ADDRESS_WIDTH-1:0] pix_index;
  logic                             wEn;
  logic [PIXEL_ADDRESS_WIDTH-1:0]   addr;
  logic [PALETTE_ADDRESS_WIDTH-1:0] dataIn;
  logic                             busy;
  logic                             done;

  modport master (
`ifdef IMAGE_WRITER_FILL_EN
    output cmd_fill, cmd_index,
`endif
    output cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, pix_valid, pix_index,
    input  cmd_ready, pix_ready, wEn, addr, dataIn, busy, done
  );

  modport slave (
`ifdef IMAGE_WRITER_FILL_EN
    input  cmd_fill, cmd_index,
`endif
    input  cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, pix_valid, pix_index,
    output cmd_ready, pix_ready, wEn, addr, dataIn, busy, done
  );
endinterface

// File: rtl/image_writer.sv
// image_writer: accepts a rectangle command and writes a stream of palette
// indices into the image-data RAM in raster order. Pixels outside the
// screen are consumed but not written.
// Ports:
//   clk     system clock, rising edge
//   resetn  asynchronous active-low reset
//   bus     image_writer_if.slave (command, pixel stream, RAM write, status)
// Optional macro IMAGE_WRITER_FILL_EN: adds a fill mode in which RUN
// produces one pixel per cycle with the latched cmd_index.
module image_writer #(
  parameter int WIDTH                 = 640,
  parameter int HEIGHT                = 480,
  parameter int PIXEL_ADDRESS_WIDTH   = $clog2(WIDTH*HEIGHT)+1,
  parameter int PALETTE_ADDRESS_WIDTH = $clog2(256)+1,
  parameter int X_WIDTH               = $clog2(WIDTH)+1,
  parameter int Y_WIDTH               = $clog2(HEIGHT)+1
) (
  input logic        clk,
  input logic        resetn,
  image_writer_if.slave bus
);
  localparam int PAW = PIXEL_ADDRESS_WIDTH;
  localparam logic [PAW-1:0]     WIDTH_A  = PAW'(WIDTH);
  localparam logic [X_WIDTH:0]   WIDTH_X  = (X_WIDTH+1)'(WIDTH);
  localparam logic [Y_WIDTH:0]   HEIGHT_Y = (Y_WIDTH+1)'(HEIGHT);

  typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_t;
  state_t state, stateNext;

  logic [X_WIDTH-1:0]               x0, w, col;
  logic [Y_WIDTH-1:0]               y0, h, row;
  logic [PAW-1:0]                   rowBase;
  logic                             fillMode;
  logic [PALETTE_ADDRESS_WIDTH-1:0] pixData;
  logic                             pixStep, lastCol, lastRow, inBounds;
  logic [X_WIDTH:0]                 xPos;
  logic [Y_WIDTH:0]                 yPos;

`ifdef IMAGE_WRITER_FILL_EN
  logic [PALETTE_ADDRESS_WIDTH-1:0] fillIndex;
  assign pixData = fillMode ? fillIndex : bus.pix_index;
`else
  assign fillMode = 1'b0;
  assign pixData  = bus.pix_index;
`endif

  assign bus.cmd_ready = (state == IDLE);
  assign bus.pix_ready = (state == RUN) && !fillMode;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);

  // In fill mode every RUN cycle is a pixel; otherwise only handshakes.
  assign pixStep = (state == RUN) && (fillMode || bus.pix_valid);
  assign lastCol = (col == w - X_WIDTH'(1));
  assign lastRow = (row == h - Y_WIDTH'(1));

  // One extra bit so x0+col / y0+row cannot wrap before the clip compare.
  assign xPos     = {1'b0, x0} + {1'b0, col};
  assign yPos     = {1'b0, y0} + {1'b0, row};
  assign inBounds = (xPos < WIDTH_X) && (yPos < HEIGHT_Y);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (bus.cmd_valid) stateNext = SETUP;
      SETUP:   stateNext = (w == '0 || h == '0) ? DONE : RUN;
      RUN:     if (pixStep && lastCol && lastRow) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x0         <= '0;
      y0         <= '0;
      w          <= '0;
      h          <= '0;
      col        <= '0;
      row        <= '0;
      rowBase    <= '0;
      bus.wEn    <= 1'b0;
      bus.addr   <= '0;
      bus.dataIn <= '0;
`ifdef IMAGE_WRITER_FILL_EN
      fillMode   <= 1'b0;
      fillIndex  <= '0;
`endif
    end else begin
      bus.wEn <= 1'b0;
      case (state)
        IDLE: if (bus.cmd_valid) begin
          x0 <= bus.cmd_x0;
          y0 <= bus.cmd_y0;
          w  <= bus.cmd_w;
          h  <= bus.cmd_h;
`ifdef IMAGE_WRITER_FILL_EN
          fillMode  <= bus.cmd_fill;
          fillIndex <= bus.cmd_index;
`endif
        end
        SETUP: begin
          // Only multiply in the design; RUN steps rowBase by WIDTH per row.
          rowBase <= PAW'(y0) * WIDTH_A + PAW'(x0);
          col     <= '0;
          row     <= '0;
        end
        RUN: if (pixStep) begin
          if (inBounds) begin
            bus.wEn    <= 1'b1;
            bus.addr   <= rowBase + PAW'(col);
            bus.dataIn <= pixData;
          end
          if (lastCol) begin
            col     <= '0;
            row     <= row + Y_WIDTH'(1);
            rowBase <= rowBase + WIDTH_A;
          end else begin
            col <= col + X_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_image_writer.sv
`timescale 1ns/1ps
module tb_image_writer;
  localparam int WIDTH  = 640;
  localparam int HEIGHT = 480;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   cyc    = 0;
  int   checks = 0;
  int   failures = 0;
  wr_t  expQ[$];
  int   doneQ[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  image_writer_if #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) bus ();
  image_writer #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every RAM write / done pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (resetn) begin
      if (bus.wEn) begin
        if (expQ.size() == 0) chk("spurious_wEn", 32'(bus.wEn), 0);
        else begin
          wr_t e;
          e = expQ.pop_front();
          chk("wr_addr", 32'(bus.addr), e.addr);
          chk("wr_data", 32'(bus.dataIn), e.data);
          chk("wr_cycle", cyc, e.cyc);
        end
      end
      if (bus.done) begin
        if (doneQ.size() == 0) chk("spurious_done", 32'(bus.done), 0);
        else chk("done_cycle", cyc, doneQ.pop_front());
      end
    end
  end

  // Issues one command and its pixels. Called with the FSM idle one negedge
  // ahead; returns on the negedge where done is visible (or after an abort).
  // gap: 0 = pix_valid held, 1 = toggled, 2 = random. seqStart<0: random data.
  task automatic runCmd(input int x0, input int y0, input int w, input int h,
                        input bit fill, input int fillIdx, input int gap,
                        input int seqStart, input int abortAfter);
    int  k;
    bit  valid;
    bit  tog;
    int  d;
    k   = 0;
    tog = 1'b1;
    @(negedge clk);
    chk("cmd_ready_idle", 32'(bus.cmd_ready), 1);
    chk("busy_idle", 32'(bus.busy), 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_x0 = 11'(x0);
    bus.cmd_y0 = 10'(y0);
    bus.cmd_w  = 11'(w);
    bus.cmd_h  = 10'(h);
`ifdef IMAGE_WRITER_FILL_EN
    bus.cmd_fill  = fill;
    bus.cmd_index = 9'(fillIdx);
`endif
    bus.pix_valid = 1'($urandom_range(0, 1));
    bus.pix_index = 9'($urandom_range(0, 511));
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("cmd_ready_setup", 32'(bus.cmd_ready), 0);
    chk("busy_setup", 32'(bus.busy), 1);
    chk("pix_ready_setup", 32'(bus.pix_ready), 0);
    if (w == 0 || h == 0) begin
      doneQ.push_back(cyc + 1);
      bus.pix_valid = 1'b0;
      @(negedge clk);
      chk("pix_ready_degenerate", 32'(bus.pix_ready), 0);
      return;
    end
    @(negedge clk);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (k == abortAfter) begin
          bus.pix_valid = 1'b0;
          #2 resetn = 1'b0;
          #1;
          chk("abort_wEn", 32'(bus.wEn), 0);
          chk("abort_done", 32'(bus.done), 0);
          chk("abort_busy", 32'(bus.busy), 0);
          @(negedge clk);
          resetn = 1'b1;
          return;
        end
        if (fill) begin
          bus.pix_valid = 1'($urandom_range(0, 1));
          chk("pix_ready_fill", 32'(bus.pix_ready), 0);
          d = fillIdx;
        end else begin
          valid = (gap == 0) ? 1'b1 : (gap == 1) ? tog : ($urandom_range(0, 2) != 0);
          tog = ~tog;
          while (!valid) begin
            bus.pix_valid = 1'b0;
            chk("pix_ready_gap", 32'(bus.pix_ready), 1);
            @(negedge clk);
            valid = (gap == 1) ? tog : ($urandom_range(0, 2) != 0);
            tog = ~tog;
          end
          d = (seqStart >= 0) ? seqStart + k : $urandom_range(0, 511);
          bus.pix_valid = 1'b1;
          bus.pix_index = 9'(d);
          chk("pix_ready_run", 32'(bus.pix_ready), 1);
        end
        chk("busy_run", 32'(bus.busy), 1);
        if (x0 + c < WIDTH && y0 + r < HEIGHT)
          expQ.push_back('{addr: (y0 + r) * WIDTH + x0 + c, data: d, cyc: cyc + 1});
        if (r == h - 1 && c == w - 1) doneQ.push_back(cyc + 1);
        k++;
        @(negedge clk);
      end
    end
    bus.pix_valid = 1'b0;
    chk("pix_ready_done", 32'(bus.pix_ready), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int x0, y0, w, h;
    bit fill;
    bus.cmd_valid = 1'b0;
    bus.cmd_x0 = '0;
    bus.cmd_y0 = '0;
    bus.cmd_w  = '0;
    bus.cmd_h  = '0;
    bus.pix_valid = 1'b0;
    bus.pix_index = '0;
`ifdef IMAGE_WRITER_FILL_EN
    bus.cmd_fill  = 1'b0;
    bus.cmd_index = '0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("rst_pix_ready", 32'(bus.pix_ready), 0);
    chk("rst_wEn", 32'(bus.wEn), 0);
    chk("rst_addr", 32'(bus.addr), 0);
    chk("rst_dataIn", 32'(bus.dataIn), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    resetn = 1'b1;

    runCmd(10, 5, 3, 2, 1'b0, 0, 0, 1, -1);      // basic raster
    runCmd(638, 479, 4, 2, 1'b0, 0, 0, 20, -1);  // bottom-right clip
    runCmd(100, 100, 0, 3, 1'b0, 0, 0, 0, -1);   // w == 0
    runCmd(100, 100, 2, 0, 1'b0, 0, 0, 0, -1);   // h == 0
    runCmd(10, 5, 3, 2, 1'b0, 0, 1, 1, -1);      // toggled pix_valid
    runCmd(200, 50, 3, 2, 1'b0, 0, 0, 40, 2);    // abort after 2 pixels
    runCmd(7, 9, 2, 2, 1'b0, 0, 0, 60, -1);      // clean restart
`ifdef IMAGE_WRITER_FILL_EN
    runCmd(0, 0, 2, 2, 1'b1, 'h1A5, 0, 0, -1);
    runCmd(638, 478, 3, 3, 1'b1, 'h0C3, 0, 0, -1);
`endif
    for (int i = 0; i < 40; i++) begin
      x0 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2040) : $urandom_range(630, 645);
      y0 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(470, 485);
      w  = $urandom_range(0, 6);
      h  = $urandom_range(0, 4);
`ifdef IMAGE_WRITER_FILL_EN
      fill = 1'($urandom_range(0, 1));
`else
      fill = 1'b0;
`endif
      runCmd(x0, y0, w, h, fill, $urandom_range(0, 511), 2, -1, -1);
    end

    repeat (4) @(negedge clk);
    chk("write_queue_drained", expQ.size(), 0);
    chk("done_queue_drained", doneQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
